// File: rtl/button_command_sequencer.sv
// button_command_sequencer: turns debounced button levels into one-cycle register commands with hold/auto-repeat
`ifndef REG_CTRL_WIDTH
`define REG_CTRL_WIDTH 3
`define REG_CTRL_NOP 3'd0
`define REG_CTRL_CLR 3'd1
`define REG_CTRL_LD  3'd2
`define REG_CTRL_INC 3'd3
`define REG_CTRL_DEC 3'd4
`endif
module button_command_sequencer #(
  parameter int unsigned HOLD_DELAY = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic                       clk,
  input  logic                       sync_reset,
  input  logic                       enable,
  input  logic                       btn_clr,
  input  logic                       btn_ld,
  input  logic                       btn_inc,
  input  logic                       btn_dec,
  output logic [`REG_CTRL_WIDTH-1:0] reg_ctrl,
  output logic                       cmd_valid,
  output logic                       busy
);
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, WAIT_RELEASE} state_t;
  localparam logic [25:0] HOLD_LIM = 26'(HOLD_DELAY - 1);
  localparam logic [25:0] REP_LIM = 26'(REPEAT_PERIOD - 1);
  state_t state_q, state_d;
  logic [25:0] cnt_q, cnt_d;
  logic [`REG_CTRL_WIDTH-1:0] sel_q, sel_d, ctrl_d, win;
  logic any_btn, sel_btn, rep_sel, due;
  // priority pick of the pressed button and status of the latched one
  always_comb begin
    win = btn_clr ? `REG_CTRL_CLR : btn_ld ? `REG_CTRL_LD : btn_inc ? `REG_CTRL_INC :
          btn_dec ? `REG_CTRL_DEC : `REG_CTRL_NOP;
    any_btn = btn_clr | btn_ld | btn_inc | btn_dec;
    sel_btn = (sel_q == `REG_CTRL_CLR) ? btn_clr : (sel_q == `REG_CTRL_LD) ? btn_ld :
              (sel_q == `REG_CTRL_INC) ? btn_inc : (sel_q == `REG_CTRL_DEC) ? btn_dec : 1'b0;
    rep_sel = (sel_q == `REG_CTRL_INC) || (sel_q == `REG_CTRL_DEC);
    due = cnt_q == ((state_q == HOLD) ? HOLD_LIM : REP_LIM);
  end
  // next state, counter, latched button and command to issue
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sel_d = sel_q;
    ctrl_d = `REG_CTRL_NOP;
    case (state_q)
      IDLE: if (enable && any_btn) begin
        ctrl_d = win;
        sel_d = win;
        cnt_d = '0;
        state_d = HOLD;
      end
      HOLD, REPEAT: begin
        if (!enable) begin
          state_d = WAIT_RELEASE;
          cnt_d = '0;
        end else if (!sel_btn) begin
          state_d = any_btn ? WAIT_RELEASE : IDLE;
          cnt_d = '0;
        end else if (!rep_sel) begin
          cnt_d = due ? cnt_q : cnt_q + 26'd1;
        end else if (due) begin
          ctrl_d = sel_q;
          cnt_d = '0;
          state_d = REPEAT;
        end else begin
          cnt_d = cnt_q + 26'd1;
        end
      end
      default: if (!any_btn) state_d = IDLE;
    endcase
  end
  // state and registered outputs; reset parks in WAIT_RELEASE so held buttons stay silent
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q <= WAIT_RELEASE;
      cnt_q <= '0;
      sel_q <= `REG_CTRL_NOP;
      reg_ctrl <= `REG_CTRL_NOP;
      cmd_valid <= 1'b0;
      busy <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      reg_ctrl <= ctrl_d;
      cmd_valid <= ctrl_d != `REG_CTRL_NOP;
      busy <= state_d != IDLE;
    end
  end
endmodule

// File: tb/tb_button_command_sequencer.sv
// tb_button_command_sequencer: directed checks of command pulses, hold/repeat timing and reset behaviour
`ifndef REG_CTRL_WIDTH
`define REG_CTRL_WIDTH 3
`define REG_CTRL_NOP 3'd0
`define REG_CTRL_CLR 3'd1
`define REG_CTRL_LD  3'd2
`define REG_CTRL_INC 3'd3
`define REG_CTRL_DEC 3'd4
`endif
module tb_button_command_sequencer;
  logic clk = 1'b0;
  logic sync_reset, enable, btn_clr, btn_ld, btn_inc, btn_dec;
  logic [`REG_CTRL_WIDTH-1:0] reg_ctrl;
  logic cmd_valid, busy;
  int n_cmp = 0;
  int n_bad = 0;
  localparam logic [2:0] NOP = `REG_CTRL_NOP;
  localparam logic [2:0] CLR = `REG_CTRL_CLR;
  localparam logic [2:0] LD = `REG_CTRL_LD;
  localparam logic [2:0] INC = `REG_CTRL_INC;
  localparam logic [2:0] DEC = `REG_CTRL_DEC;
  button_command_sequencer #(.HOLD_DELAY(4), .REPEAT_PERIOD(2)) dut (
    .clk(clk), .sync_reset(sync_reset), .enable(enable),
    .btn_clr(btn_clr), .btn_ld(btn_ld), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .reg_ctrl(reg_ctrl), .cmd_valid(cmd_valid), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic step(input logic [2:0] ec, input logic eb, input string tag);
    @(negedge clk);
    n_cmp++;
    assert (reg_ctrl === ec) else begin
      n_bad++;
      $error("FAIL %s reg_ctrl got %0d exp %0d", tag, reg_ctrl, ec);
    end
    n_cmp++;
    assert (cmd_valid === (ec != NOP)) else begin
      n_bad++;
      $error("FAIL %s cmd_valid got %0b exp %0b", tag, cmd_valid, ec != NOP);
    end
    n_cmp++;
    assert (busy === eb) else begin
      n_bad++;
      $error("FAIL %s busy got %0b exp %0b", tag, busy, eb);
    end
  endtask
  task automatic quiet(input int n, input logic eb, input string tag);
    for (int i = 0; i < n; i++) step(NOP, eb, tag);
  endtask
  initial begin
    sync_reset = 1'b1;
    enable = 1'b1;
    {btn_clr, btn_ld, btn_inc, btn_dec} = 4'b0;
    step(NOP, 1'b1, "reset");
    step(NOP, 1'b1, "reset2");
    sync_reset = 1'b0;
    step(NOP, 1'b0, "rst_release");
    step(NOP, 1'b0, "idle");
    btn_ld = 1'b1;
    step(LD, 1'b1, "ld_first");
    quiet(9, 1'b1, "ld_hold");
    btn_ld = 1'b0;
    step(NOP, 1'b0, "ld_release");
    for (int k = 0; k < 12; k++) begin
      btn_inc = 1'b1;
      step((k == 0 || k == 4 || k == 6 || k == 8 || k == 10) ? INC : NOP, 1'b1, "inc_repeat");
    end
    btn_inc = 1'b0;
    quiet(3, 1'b0, "inc_release");
    btn_dec = 1'b1;
    btn_clr = 1'b1;
    step(CLR, 1'b1, "clr_dec_first");
    quiet(3, 1'b1, "clr_hold");
    btn_clr = 1'b0;
    quiet(4, 1'b1, "dec_left_held");
    btn_dec = 1'b0;
    step(NOP, 1'b0, "dec_release");
    btn_dec = 1'b1;
    step(DEC, 1'b1, "dec_repress");
    btn_dec = 1'b0;
    step(NOP, 1'b0, "dec_release2");
    btn_inc = 1'b1;
    step(INC, 1'b1, "en_inc_first");
    quiet(3, 1'b1, "en_inc_hold");
    step(INC, 1'b1, "en_inc_second");
    quiet(1, 1'b1, "en_inc_gap");
    enable = 1'b0;
    quiet(2, 1'b1, "en_dropped");
    enable = 1'b1;
    quiet(3, 1'b1, "en_reraised");
    btn_inc = 1'b0;
    step(NOP, 1'b0, "en_release");
    btn_inc = 1'b1;
    step(INC, 1'b1, "en_repress");
    btn_inc = 1'b0;
    step(NOP, 1'b0, "en_release2");
    enable = 1'b0;
    btn_clr = 1'b1;
    quiet(3, 1'b0, "idle_disabled");
    enable = 1'b1;
    step(CLR, 1'b1, "idle_enabled");
    btn_clr = 1'b0;
    step(NOP, 1'b0, "clr_release");
    btn_inc = 1'b1;
    step(INC, 1'b1, "rst3_first");
    quiet(2, 1'b1, "rst3_hold");
    sync_reset = 1'b1;
    step(NOP, 1'b1, "rst3_reset");
    sync_reset = 1'b0;
    quiet(5, 1'b1, "rst3_held");
    btn_inc = 1'b0;
    step(NOP, 1'b0, "rst3_release");
    btn_inc = 1'b1;
    step(INC, 1'b1, "rst3_repress");
    quiet(3, 1'b1, "rst4_hold");
    sync_reset = 1'b1;
    step(NOP, 1'b1, "rst4_due_suppressed");
    sync_reset = 1'b0;
    quiet(2, 1'b1, "rst4_held");
    btn_inc = 1'b0;
    step(NOP, 1'b0, "rst4_release");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
